// File: rtl/dram_line_buffer.sv
// Direct-mapped word-level read buffer with write-through, sitting in front of a
// one-word-per-request DRAM bridge. Optional counters: DRAM_LINE_BUFFER_STATS_EN.
module dram_line_buffer #(
  parameter int LINES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        invalidate_i,
  output logic        dram_valid,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_wstrb,
  input  logic        dram_ready,
  input  logic [31:0] dram_rdata
`ifdef DRAM_LINE_BUFFER_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writes
`endif
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Line storage
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][4];

  // Accepted request
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Fill sequencing and deferred invalidate
  logic [1:0]  r_cnt;
  logic        r_gap;
  logic        r_inv_pend;

  // Registered outputs
  logic        r_dram_valid;
  logic [31:0] r_dram_addr;
  logic [31:0] r_dram_wdata;
  logic [3:0]  r_dram_wstrb;
  logic [31:0] r_cpu_rdata;

  logic [IDX-1:0]   w_in_idx;
  logic [TAG_W-1:0] w_in_tag;
  logic [1:0]       w_in_off;
  logic             w_in_write;
  logic             w_in_hit;
  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_off;
  logic             w_line_hit;
  logic             w_dram_done;
  logic             w_fill_last;
  logic             w_unused;

  assign w_in_idx   = cpu_addr[4+IDX-1:4];
  assign w_in_tag   = cpu_addr[31:4+IDX];
  assign w_in_off   = cpu_addr[3:2];
  assign w_in_write = |cpu_wstrb;
  // A same-cycle invalidate wins over the lookup, so the request becomes a miss.
  assign w_in_hit   = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag) && !invalidate_i;

  assign w_idx      = r_addr[4+IDX-1:4];
  assign w_tag      = r_addr[31:4+IDX];
  assign w_off      = r_addr[3:2];
  assign w_line_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_dram_done = r_dram_valid && dram_ready;
  assign w_fill_last = (r_state == S_FILL) && w_dram_done && (r_cnt == 2'd3);

  assign w_unused = ^cpu_addr[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid) begin
          if (w_in_write)    w_state_next = S_WRITE;
          else if (w_in_hit) w_state_next = S_RESP;
          else               w_state_next = S_FILL;
        end
      end
      S_FILL:  if (w_fill_last) w_state_next = S_RESP;
      S_WRITE: if (w_dram_done) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_cnt        <= '0;
      r_gap        <= 1'b0;
      r_inv_pend   <= 1'b0;
      r_dram_valid <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_wdata <= '0;
      r_dram_wstrb <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (invalidate_i) r_valid <= '0;
          if (cpu_valid) begin
            r_addr  <= cpu_addr[31:2];
            r_wdata <= cpu_wdata;
            r_wstrb <= cpu_wstrb;
            if (w_in_write) begin
              r_dram_valid <= 1'b1;
              r_dram_addr  <= {cpu_addr[31:2], 2'b00};
              r_dram_wdata <= cpu_wdata;
              r_dram_wstrb <= cpu_wstrb;
            end else if (w_in_hit) begin
              r_cpu_rdata <= r_data[w_in_idx][w_in_off];
            end else begin
              r_valid[w_in_idx] <= 1'b0;
              r_dram_valid      <= 1'b1;
              r_dram_addr       <= {cpu_addr[31:4], 4'b0000};
              r_dram_wstrb      <= 4'b0000;
              r_cnt             <= 2'd0;
              r_gap             <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (invalidate_i) r_inv_pend <= 1'b1;
          if (r_gap) begin
            r_gap        <= 1'b0;
            r_dram_valid <= 1'b1;
            r_dram_addr  <= r_dram_addr + 32'd4;
          end else if (w_dram_done) begin
            r_dram_valid <= 1'b0;
            r_cnt        <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_valid[w_idx] <= 1'b1;
              r_cpu_rdata    <= (w_off == 2'd3) ? dram_rdata : r_data[w_idx][w_off];
            end else begin
              r_gap <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (invalidate_i) r_inv_pend <= 1'b1;
          if (w_dram_done) begin
            r_dram_valid <= 1'b0;
            r_dram_wstrb <= 4'b0000;
          end
        end
        S_RESP: begin
          r_cpu_rdata <= '0;
          r_inv_pend  <= 1'b0;
          if (r_inv_pend || invalidate_i) r_valid <= '0;
        end
        default: r_dram_valid <= 1'b0;
      endcase
    end
  end

  // NOTE: tags and data are not reset; the valid bits alone decide whether they are meaningful.
  always_ff @(posedge clk_i) begin
    if (r_state == S_FILL && w_dram_done) r_data[w_idx][r_cnt] <= dram_rdata;
    if (w_fill_last) r_tag[w_idx] <= w_tag;
    if (r_state == S_WRITE && w_dram_done && w_line_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_data[w_idx][w_off][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

`ifdef DRAM_LINE_BUFFER_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;
  logic [31:0] r_stat_writes;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_writes <= '0;
    end else if (r_state == S_IDLE && cpu_valid) begin
      if (w_in_write)    r_stat_writes <= r_stat_writes + 32'd1;
      else if (w_in_hit) r_stat_hits   <= r_stat_hits + 32'd1;
      else               r_stat_misses <= r_stat_misses + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_writes = r_stat_writes;
`endif

  assign cpu_ready  = (r_state == S_RESP);
  assign cpu_rdata  = r_cpu_rdata;
  assign dram_valid = r_dram_valid;
  assign dram_addr  = r_dram_addr;
  assign dram_wdata = r_dram_wdata;
  assign dram_wstrb = r_dram_wstrb;

endmodule

// File: tb/tb_dram_line_buffer.sv
// Scoreboard bench for dram_line_buffer: a random-latency bridge model, a CPU driver
// that predicts responses from a tag-only reference model, and a response monitor.
module tb_dram_line_buffer;

  localparam int LINES = 4;
  localparam int IDX   = 2;

  logic        clk_i;
  logic        rst_i;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        invalidate_i;
  logic        dram_valid;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wstrb;
  logic        dram_ready;
  logic [31:0] dram_rdata;
`ifdef DRAM_LINE_BUFFER_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [31:0] stat_writes;
`endif

  dram_line_buffer #(.LINES(LINES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_valid    (cpu_valid),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wstrb    (cpu_wstrb),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .invalidate_i (invalidate_i),
    .dram_valid   (dram_valid),
    .dram_addr    (dram_addr),
    .dram_wdata   (dram_wdata),
    .dram_wstrb   (dram_wstrb),
    .dram_ready   (dram_ready),
    .dram_rdata   (dram_rdata)
`ifdef DRAM_LINE_BUFFER_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
    .stat_writes  (stat_writes)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dram_op_t;

  typedef struct {
    bit          is_write;
    logic [31:0] data;
  } cpu_exp_t;

  dram_op_t    exp_dram[$];
  cpu_exp_t    exp_cpu[$];
  logic [31:0] dram_mem [logic [31:0]];

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int unsigned s_hits, s_misses, s_writes;

  int n_checks = 0;
  int n_err    = 0;
  int beats    = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (dram_mem.exists(a)) return dram_mem[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  // Bridge: random response latency, one-cycle ready pulse, checks each request it serves.
  initial begin : bridge
    int       dly;
    bit       gap_chk;
    bit       next_gap;
    dram_op_t e;
    logic [31:0] w;
    dram_ready = 1'b0;
    dram_rdata = '0;
    dly        = -1;
    gap_chk    = 1'b0;
    next_gap   = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        dram_ready = 1'b0;
        dram_rdata = '0;
        dly        = -1;
        gap_chk    = 1'b0;
      end else if (dram_ready) begin
        dram_ready = 1'b0;
        dram_rdata = '0;
        check("dram_drop", dram_valid, 1'b0);
        gap_chk = next_gap;
      end else begin
        if (gap_chk) begin
          check("dram_reassert", dram_valid, 1'b1);
          gap_chk = 1'b0;
        end
        if (dram_valid) begin
          if (dly < 0) dly = $urandom_range(0, 3);
          if (dly == 0) begin
            dly = -1;
            if (exp_dram.size() == 0) begin
              check("dram_unexpected", dram_addr, 32'hFFFF_FFFF);
            end else begin
              e = exp_dram.pop_front();
              check("dram_addr", dram_addr, e.addr);
              check("dram_wstrb", 32'(dram_wstrb), 32'(e.wstrb));
              if (e.wstrb != 4'b0000) check("dram_wdata", dram_wdata, e.wdata);
            end
            if (dram_wstrb != 4'b0000) begin
              w = mem_rd(dram_addr);
              for (int b = 0; b < 4; b++)
                if (dram_wstrb[b]) w[8*b +: 8] = dram_wdata[8*b +: 8];
              dram_mem[dram_addr] = w;
              next_gap = 1'b0;
            end else begin
              dram_rdata = mem_rd(dram_addr);
              next_gap   = (dram_addr[3:2] != 2'd3);
            end
            dram_ready = 1'b1;
            beats++;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every cpu_ready.
  initial begin : monitor
    bit       prev_ready;
    cpu_exp_t r;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prev_ready = 1'b0;
      end else if (cpu_ready) begin
        check("ready_pulse", 32'(prev_ready), 32'd0);
        if (exp_cpu.size() == 0) begin
          check("cpu_unexpected", 32'(cpu_ready), 32'd0);
        end else begin
          r = exp_cpu.pop_front();
          if (!r.is_write) check("cpu_rdata", cpu_rdata, r.data);
        end
        prev_ready = 1'b1;
      end else begin
        if (prev_ready) check("rdata_clear", cpu_rdata, 32'd0);
        prev_ready = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit inv_same, input int inv_beat, output logic [31:0] got);
    int unsigned idx  = (a >> 4) % LINES;
    int unsigned tg   = a >> (4 + IDX);
    int          base = beats;
    int          cyc  = 0;
    int          exp_beats;
    bit          hit;
    bit          inv_done = 1'b0;
    if (inv_same) model_clear();
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (ws != 4'b0000) begin
      exp_dram.push_back('{addr: a & ~32'd3, wstrb: ws, wdata: wd});
      exp_cpu.push_back('{is_write: 1'b1, data: 32'd0});
      exp_beats = 1;
      s_writes++;
    end else if (hit) begin
      exp_cpu.push_back('{is_write: 1'b0, data: mem_rd(a & ~32'd3)});
      exp_beats = 0;
      s_hits++;
    end else begin
      for (int k = 0; k < 4; k++)
        exp_dram.push_back('{addr: (a & ~32'd15) + 32'(4 * k), wstrb: 4'b0000, wdata: 32'd0});
      exp_cpu.push_back('{is_write: 1'b0, data: mem_rd(a & ~32'd3)});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      exp_beats    = 4;
      s_misses++;
    end
    @(negedge clk_i);
    cpu_valid    = 1'b1;
    cpu_addr     = a;
    cpu_wdata    = wd;
    cpu_wstrb    = ws;
    invalidate_i = inv_same;
    got          = '0;
    do begin
      @(negedge clk_i);
      invalidate_i = 1'b0;
      cyc++;
      if (inv_beat >= 0 && !inv_done && !cpu_ready && (beats - base) == inv_beat) begin
        invalidate_i = 1'b1;
        inv_done     = 1'b1;
      end
    end while (!cpu_ready && cyc < 400);
    if (!cpu_ready) check("cpu_timeout", 32'(cyc), 32'd0);
    else            got = cpu_rdata;
    cpu_valid = 1'b0;
    if (inv_done) model_clear();
    if (ws == 4'b0000 && hit) check("hit_latency", 32'(cyc), 32'd1);
    check("dram_beats", 32'(beats - base), 32'(exp_beats));
    check("dram_ops_left", 32'(exp_dram.size()), 32'd0);
  endtask

  task automatic pulse_inv();
    @(negedge clk_i);
    invalidate_i = 1'b1;
    @(negedge clk_i);
    invalidate_i = 1'b0;
    model_clear();
  endtask

  initial begin : driver
    logic [31:0] got;
    logic [31:0] a;
    int          base;
    int          cyc;
    int          r;
    rst_i        = 1'b0;
    cpu_valid    = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    cpu_wstrb    = '0;
    invalidate_i = 1'b0;
    s_hits = 0; s_misses = 0; s_writes = 0;
    model_clear();
    dram_mem[32'h1000] = 32'h11;
    dram_mem[32'h1004] = 32'h22;
    dram_mem[32'h1008] = 32'h33;
    dram_mem[32'h100C] = 32'h44;

    repeat (3) @(negedge clk_i);
    check("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset_cpu_rdata", cpu_rdata, 32'd0);
    check("reset_dram_valid", 32'(dram_valid), 32'd0);
    check("reset_dram_addr", dram_addr, 32'd0);
    check("reset_dram_wdata", dram_wdata, 32'd0);
    check("reset_dram_wstrb", 32'(dram_wstrb), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    do_req(32'h0000_1008, 32'd0, 4'b0000, 1'b0, -1, got);
    check("cold_read", got, 32'h33);
    do_req(32'h0000_100C, 32'd0, 4'b0000, 1'b0, -1, got);
    check("hit_read", got, 32'h44);
    do_req(32'h0000_1004, 32'hAABB_CCDD, 4'b0011, 1'b0, -1, got);
    do_req(32'h0000_1004, 32'd0, 4'b0000, 1'b0, -1, got);
    check("write_merge", got, 32'h0000_CCDD);

    pulse_inv();
    do_req(32'h0000_1000, 32'd0, 4'b0000, 1'b0, -1, got);
    do_req(32'h0000_1040, 32'd0, 4'b0000, 1'b0, -1, got);
    do_req(32'h0000_1000, 32'd0, 4'b0000, 1'b0, -1, got);
    check("evict_reread", got, 32'h11);

    do_req(32'h0000_2000, 32'd0, 4'b0000, 1'b0, 1, got);
    do_req(32'h0000_2000, 32'd0, 4'b0000, 1'b0, -1, got);
    do_req(32'h0000_2000, 32'd0, 4'b0000, 1'b1, -1, got);
    do_req(32'h0000_2004, 32'd0, 4'b0000, 1'b0, -1, got);

    for (int n = 0; n < 80; n++) begin
      a = 32'h0000_3000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 3) << 4)
        + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
      r = $urandom_range(0, 19);
      if (r == 0) pulse_inv();
      if ($urandom_range(0, 9) < 3)
        do_req(a, $urandom, 4'($urandom_range(1, 15)), (r == 1), (r == 2) ? $urandom_range(0, 3) : -1, got);
      else
        do_req(a, 32'd0, 4'b0000, (r == 1), (r == 2) ? $urandom_range(0, 3) : -1, got);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

`ifdef DRAM_LINE_BUFFER_STATS_EN
    check("stat_hits", stat_hits, 32'(s_hits));
    check("stat_misses", stat_misses, 32'(s_misses));
    check("stat_writes", stat_writes, 32'(s_writes));
`endif
    $display("Info: model hits=%0d misses=%0d writes=%0d", s_hits, s_misses, s_writes);

    // Reset in the middle of a fill, then a fresh fill of the same line.
    pulse_inv();
    base = beats;
    for (int k = 0; k < 4; k++)
      exp_dram.push_back('{addr: 32'h1000 + 32'(4 * k), wstrb: 4'b0000, wdata: 32'd0});
    @(negedge clk_i);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_1000;
    cpu_wstrb = 4'b0000;
    cyc = 0;
    while ((beats - base) < 1 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check("rst_fill_started", 32'(beats - base), 32'd1);
    rst_i     = 1'b0;
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_dram_valid", 32'(dram_valid), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    exp_dram.delete();
    exp_cpu.delete();
    model_clear();
    s_hits = 0; s_misses = 0; s_writes = 0;
    rst_i = 1'b1;
    @(negedge clk_i);
    do_req(32'h0000_1000, 32'd0, 4'b0000, 1'b0, -1, got);
    check("post_reset_read", got, 32'h11);
`ifdef DRAM_LINE_BUFFER_STATS_EN
    check("post_reset_misses", stat_misses, 32'd1);
`endif

    repeat (3) @(negedge clk_i);
    check("cpu_exp_left", 32'(exp_cpu.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_line_buffer.md
Name: dram_line_buffer

Overview:
- Word-level read buffer with write-through, placed directly upstream of the DRAM bridge; the bridge accesses memory one 32-bit word per request.
- Holds LINES direct-mapped 128-bit lines. Read hits are served locally.
- A read miss fetches the whole 4-word line from the bridge as four sequential word reads.
- Writes always pass through to the bridge and update the buffered line on a hit.

Parameters:
- LINES, 4: number of lines; power of 2, >=2. IDX = log2(LINES).

Ports:
- clk_i  in  1  clock; bridge UI clock domain
- rst_i  in  1  synchronous, active-low reset
- cpu_valid  in  1  request; held until cpu_ready
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte enables; 0 = read, nonzero = write
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid when cpu_ready is high, 0 otherwise
- invalidate_i  in  1  clear all line valid bits
- dram_valid  out  1  bridge request; held until dram_ready
- dram_addr  out  32  word address to bridge
- dram_wdata  out  32  write data to bridge
- dram_wstrb  out  4  byte enables to bridge; 0 = read
- dram_ready  in  1  bridge completion pulse
- dram_rdata  in  32  bridge read data; valid with dram_ready

Behaviour:
- Address fields: word offset = addr[3:2]; index = addr[4+IDX-1:4]; tag = addr[31:4+IDX].
- Storage per line: valid bit, tag, 4x32 data.
- Reset (rst_i==0 at a clock edge):
  - all valid bits cleared; state IDLE;
  - cpu_ready, cpu_rdata, dram_valid, dram_addr, dram_wdata, dram_wstrb all 0.
  - An in-flight bridge transaction is abandoned; the bridge shares this reset.
- States: IDLE, FILL, WRITE, RESP.
- IDLE, when cpu_valid is sampled high:
  - Read hit (valid & tag match): go to RESP; the selected word is registered into cpu_rdata. cpu_ready rises exactly 1 cycle after the cycle cpu_valid was sampled.
  - Read miss: go to FILL with word counter = 0. dram_addr = {addr[31:4], 4'b0000}, dram_wstrb = 0, dram_valid = 1.
  - Write: go to WRITE. dram_addr = {addr[31:2],2'b00}, dram_wdata = cpu_wdata, dram_wstrb = cpu_wstrb, dram_valid = 1.
- FILL:
  - On each dram_ready, store dram_rdata into word[counter] of the line and increment the counter.
  - dram_valid drops for exactly 1 cycle, then reasserts with dram_addr + 4.
  - After word 3: set the tag, set valid, load the requested word into cpu_rdata, go to RESP.
  - The line is marked valid only after all 4 words have arrived.
- WRITE: on dram_ready, drop dram_valid. If the line hits, merge cpu_wdata bytes selected by cpu_wstrb into the buffered word. Go to RESP.
  - Write miss: no allocate; the buffer is unchanged.
- RESP: cpu_ready = 1 for one cycle; next state IDLE. cpu_valid must drop on the following cycle; the block ignores cpu_valid during RESP.
- cpu_addr, cpu_wdata and cpu_wstrb must be stable while cpu_valid is high; they are registered at acceptance.
- Latency: read hit = 2 cycles (valid to ready inclusive); miss = 4 bridge round trips + 3 gap cycles + 1; write = 1 bridge round trip + 1.
- invalidate_i:
  - In IDLE: all valid bits are cleared that cycle. If cpu_valid is also high in that cycle, the request is treated as a miss.
  - In FILL, WRITE or RESP: the invalidate is latched as pending and applied on entry to IDLE. The line currently filling is also cleared by the pending invalidate.
- Index wrap: addresses differing only in tag map to the same line. A fill evicts the previous line with no writeback, since lines are always clean.
- dram_ready outside FILL/WRITE: ignored.
- cpu_valid during FILL/WRITE: not accepted until back in IDLE.

Optional Feature:
- Macro: DRAM_LINE_BUFFER_STATS_EN.
- When defined, three output ports are added:
  - stat_hits (32): +1 per read hit;
  - stat_misses (32): +1 per fill started;
  - stat_writes (32): +1 per write accepted.
- All three counters reset to 0 and wrap modulo 2^32. They are not affected by invalidate_i.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold read 0x0000_1008; bridge returns 0x11,0x22,0x33,0x44 for 0x1000..0x100C -> four bridge reads at 0x1000,0x1004,0x1008,0x100C; cpu_rdata=0x33 with one cpu_ready pulse.
- Read 0x0000_100C after the previous test -> no dram_valid; cpu_rdata=0x44 two cycles after cpu_valid.
- Write 0x0000_1004, wdata 0xAABBCCDD, wstrb 4'b0011, then read 0x1004 -> bridge sees the write with wstrb 0011; the read hits and returns 0x0000CCDD (old 0x22 upper bytes zero).
- LINES=4: read 0x1000, then 0x1040 (same index, new tag), then 0x1000 -> three fills; the last read misses.
- Assert invalidate_i during the 2nd fill beat of 0x2000, then read 0x2000 -> second fill issued; the line is not left valid.
- Pull rst_i low mid-FILL, release, read 0x1000 -> dram_valid 0 during reset, then a fresh 4-beat fill; cpu_ready only after the fill; with DRAM_LINE_BUFFER_STATS_EN, stat_misses=1.
